// File: rtl/tick_scheduler.sv
// Shared-prescaler tick scheduler: one base tick divider feeding NUM_CH programmable
// channel dividers that emit single-cycle enable pulses on clk_in.

module tick_channel #(
  parameter int PERIOD_W       = 10,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                base_tick,
  input  logic                wr_en,
  input  logic [PERIOD_W-1:0] wr_period,
  output logic                tick
);

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;

  // A config write on this channel takes priority over a coincident base tick.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      period <= PERIOD_W'(DEFAULT_PERIOD);
      cnt    <= '0;
      tick   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (wr_en) begin
        period <= wr_period;
        cnt    <= '0;
      end else if (base_tick && period != '0) begin
        if (cnt == period - PERIOD_W'(1)) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + PERIOD_W'(1);
        end
      end
    end
  end

endmodule

module tick_scheduler #(
  parameter int PRESCALE       = 40000,
  parameter int PRE_W          = 16,
  parameter int NUM_CH         = 3,
  parameter int PERIOD_W       = 10,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cfg_valid,
  input  logic [1:0]          cfg_ch,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic                cfg_ready,
  output logic                base_tick,
  output logic [NUM_CH-1:0]   ch_tick,
  output logic                running
);

  typedef enum logic [1:0] {IDLE, RUN, CFG_I, CFG_R} state_t;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  state_t              state, state_nxt;
  logic                cfg_fire;
  logic                wr_active;
  logic [1:0]          cap_ch;
  logic [PERIOD_W-1:0] cap_period;
  logic [PRE_W-1:0]    pre_cnt;
  logic [NUM_CH-1:0]   wr_en;

  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign running   = (state == RUN)  || (state == CFG_R);
  assign wr_active = (state == CFG_I) || (state == CFG_R);
  assign cfg_fire  = cfg_valid & cfg_ready;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A config handshake outranks enable; enable is re-sampled on leaving CFG_R.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_fire) state_nxt = CFG_I;
               else if (enable) state_nxt = RUN;
      RUN:     if (cfg_fire) state_nxt = CFG_R;
               else if (!enable) state_nxt = IDLE;
      CFG_I:   state_nxt = IDLE;
      CFG_R:   state_nxt = enable ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cap_ch     <= '0;
      cap_period <= '0;
    end else if (cfg_fire) begin
      cap_ch     <= cfg_ch;
      cap_period <= cfg_period;
    end
  end

  // Prescaler holds its count while paused so phase survives a pause.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt   <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= 1'b0;
      if (running) begin
        if (pre_cnt == PRE_MAX) begin
          pre_cnt   <= '0;
          base_tick <= 1'b1;
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end
    end
  end

  // Out-of-range channel indices match no lane, so such writes are no-ops.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_en[i] = wr_active && (cap_ch == 2'(i));

    tick_channel #(
      .PERIOD_W       (PERIOD_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .base_tick (base_tick),
      .wr_en     (wr_en[i]),
      .wr_period (cap_period),
      .tick      (ch_tick[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed, table-driven bench for tick_scheduler (PRESCALE=4, DEFAULT_PERIOD=3, NUM_CH=3).

module tb_tick_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       cfg_valid;
  logic [1:0] cfg_ch;
  logic [9:0] cfg_period;
  logic       cfg_ready;
  logic       base_tick;
  logic [2:0] ch_tick;
  logic       running;

  int n_tests = 0;
  int n_fail  = 0;

  tick_scheduler #(
    .PRESCALE       (4),
    .PRE_W          (16),
    .NUM_CH         (3),
    .PERIOD_W       (10),
    .DEFAULT_PERIOD (3)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_ready  (cfg_ready),
    .base_tick  (base_tick),
    .ch_tick    (ch_tick),
    .running    (running)
  );

  always #5 clk_in = ~clk_in;

  // n cycles of the same inputs, each cycle checked against the same outputs
  typedef struct packed {
    int         n;
    logic       en;
    logic       cv;
    logic [1:0] ch;
    logic [9:0] per;
    logic       bt;
    logic [2:0] ct;
    logic       run;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int n, logic en, logic cv, logic [1:0] ch, logic [9:0] per,
                              logic bt, logic [2:0] ct, logic run, logic rdy);
    vec_t v;
    v = '{n, en, cv, ch, per, bt, ct, run, rdy};
    tbl.push_back(v);
  endfunction

  function automatic void q(int n);          add(n, 1, 0, 0, 0, 0, 3'b000, 1, 1); endfunction
  function automatic void b();               add(1, 1, 0, 0, 0, 1, 3'b000, 1, 1); endfunction
  function automatic void t(logic [2:0] ct); add(1, 1, 0, 0, 0, 0, ct, 1, 1);     endfunction
  function automatic void w(logic [1:0] ch, logic [9:0] per, logic bt);
    add(1, 1, 1, ch, per, bt, 3'b000, 1, 0);
  endfunction

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic chk(string name, logic bt, logic [2:0] ct, logic run, logic rdy);
    n_tests++;
    if ({base_tick, ch_tick, running, cfg_ready} !== {bt, ct, run, rdy}) begin
      n_fail++;
      $display("FAIL %s: got bt=%b ct=%b run=%b rdy=%b, expected bt=%b ct=%b run=%b rdy=%b",
               name, base_tick, ch_tick, running, cfg_ready, bt, ct, run, rdy);
    end
  endtask

  initial begin
    // 1: free running from reset
    q(4); b(); q(3); b(); q(3); b(); t(3'b111);
    q(2); b(); q(3); b(); q(3); b(); t(3'b111);
    // 2: ch1 period 1 while running
    w(2'd1, 10'd1, 0); q(1); b(); t(3'b010); q(2); b(); t(3'b010); q(2); b(); t(3'b111);
    // 3: pause 10 cycles with 3 prescale cycles already counted
    q(1); add(10, 0, 0, 0, 0, 0, 3'b000, 0, 1); q(1); b(); t(3'b010);
    // 4: ch0 disabled, then period 5
    w(2'd0, 10'd0, 0); q(1); b(); t(3'b010); q(2); b(); t(3'b110);
    w(2'd0, 10'd5, 0); q(1); b(); t(3'b010); q(2); b(); t(3'b010);
    q(2); b(); t(3'b110); q(2); b(); t(3'b010); q(2); b(); t(3'b011);
    // 5: ch2 write collides with its completing base tick; then ch3 write is a no-op
    q(2); w(2'd2, 10'd3, 1); t(3'b010); w(2'd3, 10'd7, 0); q(1);
    b(); t(3'b010); q(2); b(); t(3'b010); q(2); b(); t(3'b110); q(2); b(); t(3'b011);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0;
    #3;
    chk("reset_state", 0, 3'b000, 0, 1);
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("reset_hold%0d", i), 0, 3'b000, 0, 1);
    end
    rst_n = 1'b1; enable = 1'b0;

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].n; r++) begin
        enable = tbl[i].en; cfg_valid = tbl[i].cv; cfg_ch = tbl[i].ch; cfg_period = tbl[i].per;
        step();
        chk($sformatf("vec%0d_%0d", i, r), tbl[i].bt, tbl[i].ct, tbl[i].run, tbl[i].rdy);
      end
    end

    // 6a: reset while in CFG_R aborts the write
    enable = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_period = 10'd2;
    step();
    chk("t6_cfg_r", 0, 3'b000, 1, 0);
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cfg_r", 0, 3'b000, 0, 1);
    @(negedge clk_in);
    rst_n = 1'b1; enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("t6_idle%0d", i), 0, 3'b000, 0, 1);
    end

    // 6b: periods back to 3 on all channels; reset during the ch_tick pulse
    enable = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      chk($sformatf("t6_run%0d", k), (k == 4 || k == 8 || k == 12),
          (k == 13) ? 3'b111 : 3'b000, 1, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_tick", 0, 3'b000, 0, 1);
    @(negedge clk_in);
    rst_n = 1'b1; enable = 1'b0;
    step();
    chk("t6_idle_after", 0, 3'b000, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
